ul_master_arb: RTL and testbench

//  Two-master to one-slave arbiter for the UL register bus. Lets the PCIe-to-UL bridge (port s0) and a second

---
 rtl/ul_master_arb_if.sv | 19 +
 rtl/ul_master_arb.sv | 76 +++++++
 tb/tb_ul_master_arb.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ul_master_arb_if.sv
// ul_master_arb_if: one UL register-bus port, a write channel plus a single-beat read channel.
interface ul_master_arb_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  wvalid;
  logic                  wready;
  logic                  arvalid;
  logic                  arready;
  logic                  rvalid;
  logic                  rready;
  modport master (output waddr, wdata, wvalid, araddr, arvalid, rready,
                  input  wready, arready, rdata, rvalid);
  modport slave  (input  waddr, wdata, wvalid, araddr, arvalid, rready,
                  output wready, arready, rdata, rvalid);
endinterface

// File: rtl/ul_master_arb.sv
// ul_master_arb: two-master UL bus arbiter, round-robin write and read channels, single outstanding read
module ul_master_arb #(
  parameter int ADDR_WIDTH = 10
) (
  input logic            clk,
  input logic            rst_n,
  ul_master_arb_if.slave  s0,
  ul_master_arb_if.slave  s1,
  ul_master_arb_if.master m
);
  localparam logic [1:0] RD_IDLE = 2'd0, RD_ADDR = 2'd1, RD_DATA = 2'd2;
  logic [1:0] rd_state;
  logic rd_owner, w_last, r_last;
  logic wfree, w_sel, w_go, r_sel, r_go, in_data;
  logic [ADDR_WIDTH-1:0] w_addr, r_addr;
  assign wfree   = ~m.wvalid | m.wready;
  assign w_sel   = (s0.wvalid & s1.wvalid) ? ~w_last : s1.wvalid;
  // ready outputs are forced low while reset is held, even if masters keep their valids up
  assign w_go    = rst_n & wfree & (s0.wvalid | s1.wvalid);
  assign w_addr  = w_sel ? s1.waddr : s0.waddr;
  assign r_sel   = (s0.arvalid & s1.arvalid) ? ~r_last : s1.arvalid;
  assign r_go    = rst_n & (rd_state == RD_IDLE) & ~m.wvalid & (s0.arvalid | s1.arvalid);
  assign r_addr  = r_sel ? s1.araddr : s0.araddr;
  assign in_data = rd_state == RD_DATA;
  assign s0.wready  = w_go & ~w_sel;
  assign s1.wready  = w_go & w_sel;
  assign s0.arready = r_go & ~r_sel;
  assign s1.arready = r_go & r_sel;
  assign s0.rdata   = m.rdata;
  assign s1.rdata   = m.rdata;
  assign s0.rvalid  = in_data & ~rd_owner & m.rvalid;
  assign s1.rvalid  = in_data & rd_owner & m.rvalid;
  assign m.rready   = in_data & (rd_owner ? s1.rready : s0.rready);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m.wvalid <= 1'b0;
      m.waddr  <= '0;
      m.wdata  <= '0;
      w_last   <= 1'b1;
    end else if (w_go) begin
      m.wvalid <= 1'b1;
      m.waddr  <= w_addr;
      m.wdata  <= w_sel ? s1.wdata : s0.wdata;
      w_last   <= w_sel;
    end else if (m.wready) begin
      m.wvalid <= 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state  <= RD_IDLE;
      rd_owner  <= 1'b0;
      r_last    <= 1'b1;
      m.arvalid <= 1'b0;
      m.araddr  <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: if (r_go) begin
          m.araddr  <= r_addr;
          m.arvalid <= 1'b1;
          rd_owner  <= r_sel;
          rd_state  <= RD_ADDR;
        end
        RD_ADDR: if (m.arready) begin
          m.arvalid <= 1'b0;
          rd_state  <= RD_DATA;
        end
        RD_DATA: if (m.rvalid & m.rready) begin
          r_last   <= rd_owner;
          rd_state <= RD_IDLE;
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ul_master_arb.sv
// tb_ul_master_arb: directed vectors for the UL two-master arbiter.
module tb_ul_master_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int passed = 0;
  always #5 clk = ~clk;
  ul_master_arb_if #(.ADDR_WIDTH(10)) s0_if ();
  ul_master_arb_if #(.ADDR_WIDTH(10)) s1_if ();
  ul_master_arb_if #(.ADDR_WIDTH(10)) m_if ();
  ul_master_arb #(.ADDR_WIDTH(10)) dut (.clk(clk), .rst_n(rst_n), .s0(s0_if), .s1(s1_if), .m(m_if));
  typedef struct {
    logic s0v, s1v, wr;
    logic e0, e1, ewv;
    logic [9:0] ea;
    logic [31:0] ed;
  } wvec_t;
  wvec_t wv[13];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int own[3];
    own = '{0, 1, 0};
    wv[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 10'h010, 32'hA0};
    wv[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 10'h020, 32'hB0};
    wv[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 10'h010, 32'hA0};
    wv[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 10'h020, 32'hB0};
    wv[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h020, 32'hB0};
    wv[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'h010, 32'hA0};
    wv[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h010, 32'hA0};
    wv[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'h020, 32'hB0};
    wv[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 10'h020, 32'hB0};
    wv[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h020, 32'hB0};
    wv[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 10'h010, 32'hA0};
    wv[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h010, 32'hA0};
    wv[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h010, 32'hA0};
    s0_if.waddr = 10'h010; s0_if.wdata = 32'hA0; s0_if.wvalid = 1'b0;
    s1_if.waddr = 10'h020; s1_if.wdata = 32'hB0; s1_if.wvalid = 1'b0;
    s0_if.araddr = '0; s0_if.arvalid = 1'b0; s0_if.rready = 1'b0;
    s1_if.araddr = '0; s1_if.arvalid = 1'b0; s1_if.rready = 1'b0;
    m_if.wready = 1'b0; m_if.arready = 1'b0; m_if.rdata = '0; m_if.rvalid = 1'b0;
    #2;
    chk("rst m_wvalid", m_if.wvalid, 0);
    chk("rst m_arvalid", m_if.arvalid, 0);
    chk("rst m_waddr", m_if.waddr, 0);
    chk("rst m_wdata", m_if.wdata, 0);
    chk("rst m_araddr", m_if.araddr, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      s0_if.wvalid = wv[i].s0v; s1_if.wvalid = wv[i].s1v; m_if.wready = wv[i].wr;
      #1;
      chk($sformatf("w%0d s0_wready", i), s0_if.wready, wv[i].e0);
      chk($sformatf("w%0d s1_wready", i), s1_if.wready, wv[i].e1);
      tick();
      chk($sformatf("w%0d m_wvalid", i), m_if.wvalid, wv[i].ewv);
      chk($sformatf("w%0d m_waddr", i), m_if.waddr, wv[i].ea);
      chk($sformatf("w%0d m_wdata", i), m_if.wdata, wv[i].ed);
    end
    // stalled write holds its beat
    s0_if.wvalid = 1'b1; m_if.wready = 1'b0;
    #1;
    chk("stall accept", s0_if.wready, 1);
    tick();
    s0_if.waddr = 10'h011;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall m_wvalid", m_if.wvalid, 1);
      chk("stall m_waddr", m_if.waddr, 10'h010);
      chk("stall s0_wready", s0_if.wready, 0);
      tick();
    end
    s0_if.wvalid = 1'b0; m_if.wready = 1'b1;
    tick();
    chk("stall drain", m_if.wvalid, 0);
    // read waits for the earlier write to drain
    s0_if.wvalid = 1'b1; s0_if.waddr = 10'h005; m_if.wready = 1'b0;
    tick();
    chk("wbr write out", m_if.waddr, 10'h005);
    s0_if.wvalid = 1'b0; s0_if.arvalid = 1'b1; s0_if.araddr = 10'h005;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("wbr s0_arready", s0_if.arready, 0);
      tick();
      chk("wbr m_arvalid", m_if.arvalid, 0);
    end
    m_if.wready = 1'b1;
    #1;
    chk("wbr arready at drain", s0_if.arready, 0);
    tick();
    #1;
    chk("wbr arready after", s0_if.arready, 1);
    tick();
    chk("wbr m_arvalid", m_if.arvalid, 1);
    chk("wbr m_araddr", m_if.araddr, 10'h005);
    s0_if.arvalid = 1'b0; m_if.wready = 1'b0; m_if.arready = 1'b1;
    #1;
    chk("wbr addr arready", s0_if.arready, 0);
    tick();
    chk("wbr arvalid drop", m_if.arvalid, 0);
    m_if.arready = 1'b0; m_if.rvalid = 1'b1; m_if.rdata = 32'h12345678; s0_if.rready = 1'b1;
    #1;
    chk("wbr s0_rvalid", s0_if.rvalid, 1);
    chk("wbr s1_rvalid", s1_if.rvalid, 0);
    chk("wbr m_rready", m_if.rready, 1);
    chk("wbr s0_rdata", s0_if.rdata, 32'h12345678);
    tick();
    m_if.rvalid = 1'b0; s0_if.rready = 1'b0;
    // s1 read with a slow slave
    s1_if.arvalid = 1'b1; s1_if.araddr = 10'h3FF; s1_if.rready = 1'b1;
    #1;
    chk("rd1 s1_arready", s1_if.arready, 1);
    chk("rd1 s0_arready", s0_if.arready, 0);
    tick();
    s1_if.arvalid = 1'b0;
    chk("rd1 m_arvalid", m_if.arvalid, 1);
    chk("rd1 m_araddr", m_if.araddr, 10'h3FF);
    m_if.arready = 1'b1;
    tick();
    m_if.arready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rd1 wait s1_rvalid", s1_if.rvalid, 0);
      tick();
    end
    m_if.rvalid = 1'b1; m_if.rdata = 32'hDEADBEEF;
    #1;
    chk("rd1 s1_rvalid", s1_if.rvalid, 1);
    chk("rd1 s0_rvalid", s0_if.rvalid, 0);
    chk("rd1 s1_rdata", s1_if.rdata, 32'hDEADBEEF);
    chk("rd1 m_rready", m_if.rready, 1);
    tick();
    m_if.rvalid = 1'b0; s1_if.rready = 1'b0;
    // both masters read continuously
    s0_if.araddr = 10'h100; s1_if.araddr = 10'h200;
    s0_if.arvalid = 1'b1; s1_if.arvalid = 1'b1; s0_if.rready = 1'b1; s1_if.rready = 1'b1;
    m_if.arready = 1'b1; m_if.rvalid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      #1;
      chk($sformatf("rr%0d s0_arready", r), s0_if.arready, own[r] == 0);
      chk($sformatf("rr%0d s1_arready", r), s1_if.arready, own[r] == 1);
      tick();
      chk($sformatf("rr%0d m_araddr", r), m_if.araddr, own[r] == 1 ? 10'h200 : 10'h100);
      #1;
      chk($sformatf("rr%0d addr arready", r), s0_if.arready | s1_if.arready, 0);
      chk($sformatf("rr%0d addr rvalid", r), s0_if.rvalid | s1_if.rvalid, 0);
      tick();
      #1;
      chk($sformatf("rr%0d s0_rvalid", r), s0_if.rvalid, own[r] == 0);
      chk($sformatf("rr%0d s1_rvalid", r), s1_if.rvalid, own[r] == 1);
      chk($sformatf("rr%0d data arready", r), s0_if.arready | s1_if.arready, 0);
      tick();
    end
    s0_if.arvalid = 1'b0; s1_if.arvalid = 1'b0; s0_if.rready = 1'b0; s1_if.rready = 1'b0;
    m_if.arready = 1'b0; m_if.rvalid = 1'b0;
    // async reset in RD_DATA
    s0_if.arvalid = 1'b1;
    tick();
    s0_if.arvalid = 1'b0; m_if.arready = 1'b1;
    tick();
    m_if.arready = 1'b0; m_if.rvalid = 1'b1; s0_if.rready = 1'b1;
    #1;
    chk("rst6 pre s0_rvalid", s0_if.rvalid, 1);
    rst_n = 1'b0; s0_if.arvalid = 1'b1;
    #1;
    chk("rst6 s0_rvalid", s0_if.rvalid, 0);
    chk("rst6 m_rready", m_if.rready, 0);
    chk("rst6 m_arvalid", m_if.arvalid, 0);
    chk("rst6 s0_arready", s0_if.arready, 0);
    rst_n = 1'b1; s0_if.arvalid = 1'b0; m_if.rvalid = 1'b0; s0_if.rready = 1'b0;
    // async reset with a write beat pending
    s1_if.wvalid = 1'b1; m_if.wready = 1'b0;
    tick();
    chk("rst6 pre m_wvalid", m_if.wvalid, 1);
    s0_if.wvalid = 1'b1; s0_if.waddr = 10'h010;
    rst_n = 1'b0;
    #1;
    chk("rst6 m_wvalid", m_if.wvalid, 0);
    chk("rst6 m_waddr", m_if.waddr, 0);
    chk("rst6 m_wdata", m_if.wdata, 0);
    chk("rst6 s0_wready", s0_if.wready, 0);
    chk("rst6 s1_wready", s1_if.wready, 0);
    rst_n = 1'b1; s0_if.arvalid = 1'b1; s1_if.arvalid = 1'b1;
    #1;
    chk("post s0_wready", s0_if.wready, 1);
    chk("post s1_wready", s1_if.wready, 0);
    chk("post s0_arready", s0_if.arready, 1);
    chk("post s1_arready", s1_if.arready, 0);
    tick();
    chk("post m_waddr", m_if.waddr, 10'h010);
    chk("post m_arvalid", m_if.arvalid, 1);
    chk("post m_araddr", m_if.araddr, 10'h100);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
